// File: rtl/npu_cfg_pkg.sv
// Shared definitions for the SSFR configuration frame receiver.
//   state_t      : frame parser states
//   err_cause_t  : reason for an ERR pulse (debug visibility)
//   SSFR_RST_VAL : SSFR reset value; DA/DB reset halves derive from it
//   SYNC_DEF / CMD_WR_DEF : default frame marker and write command code
package npu_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S_CMD,
    S_A,
    S_B,
    S_CHK,
    COMMIT
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_BAD_CMD,
    CAUSE_BAD_CHK,
    CAUSE_TIMEOUT
  } err_cause_t;

  localparam logic [15:0] SSFR_RST_VAL = 16'h2280;
  localparam logic [7:0]  DA_RST       = SSFR_RST_VAL[15:8];
  localparam logic [7:0]  DB_RST       = SSFR_RST_VAL[7:0];

  localparam logic [7:0]  SYNC_DEF     = 8'hA5;
  localparam logic [7:0]  CMD_WR_DEF   = 8'h01;

endpackage

// File: rtl/cfg_timeout_ctr.sv
// Inter-byte idle counter for the frame receiver.
// Ports:
//   CLKEXT   : clock
//   RST      : synchronous active-high reset
//   clr      : clear counter to zero (highest priority after reset)
//   load     : load counter with load_val
//   load_val : value to load
//   inc      : count one idle cycle
//   expired  : this idle cycle is the LIMIT-th in a row (combinational);
//              never asserts when LIMIT is 0
module cfg_timeout_ctr #(
  parameter int unsigned TO_W  = 16,
  parameter int unsigned LIMIT = 1000
) (
  input  logic            CLKEXT,
  input  logic            RST,
  input  logic            clr,
  input  logic            load,
  input  logic [TO_W-1:0] load_val,
  input  logic            inc,
  output logic            expired
);

  // Expiry is flagged while the count still shows LIMIT-1, so the cycle that
  // completes LIMIT idle cycles is the one that reports it.
  localparam logic [TO_W-1:0] LAST = TO_W'(LIMIT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge CLKEXT) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign expired = (LIMIT != 0) && inc && (cnt == LAST);

endmodule

// File: rtl/cfg_frame_rx.sv
// Byte-serial configuration frame receiver feeding the SSFR.
// Hunts SYNC_BYTE, parses a write frame and, on success, loads DA/DB and
// pulses EN_CONFIG for one cycle so the SSFR captures {DA, DB}.
// Build option: define CFG_FRAME_CHK_EN for the 5-byte frame
// (SYNC, CMD, A, B, CHK with CHK = CMD ^ A ^ B). Without it the frame is
// 4 bytes (SYNC, CMD, A, B) and no checksum is checked.
// Ports:
//   CLKEXT, RST        : clock, synchronous active-high reset
//   RX_DATA, RX_VALID  : incoming byte stream
//   RX_READY           : byte accepted (low only during the commit cycle)
//   DA, DB             : payload bytes, registered, held between commits
//   EN_CONFIG          : one-cycle SSFR load strobe
//   BUSY               : parser is not idle
//   ERR, ERR_CNT       : one-cycle error pulse, saturating error count
module cfg_frame_rx
  import npu_cfg_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_DEF,
  parameter logic [7:0]  CMD_WR    = CMD_WR_DEF,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned TO_W      = 16
) (
  input  logic       CLKEXT,
  input  logic       RST,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic       RX_READY,
  output logic [7:0] DA,
  output logic [7:0] DB,
  output logic       EN_CONFIG,
  output logic       BUSY,
  output logic       ERR,
  output logic [7:0] ERR_CNT
);

  state_t     state, state_nxt;
  err_cause_t cause;
  logic       hs;
  logic       in_frame;
  logic       to_exp;
  logic [7:0] shadow_a;
  logic [7:0] db_load;
`ifdef CFG_FRAME_CHK_EN
  logic [7:0] shadow_b;
`endif

  assign hs       = RX_VALID & RX_READY;
  assign in_frame = (state != IDLE) && (state != COMMIT);

  assign RX_READY  = (state != COMMIT);
  assign EN_CONFIG = (state == COMMIT);
  assign BUSY      = (state != IDLE);

  // Idle timer only runs between bytes inside a frame; any handshake
  // restarts it, so a byte arriving on the expiry cycle wins.
  cfg_timeout_ctr #(
    .TO_W  (TO_W),
    .LIMIT (TIMEOUT)
  ) u_to (
    .CLKEXT   (CLKEXT),
    .RST      (RST),
    .clr      (hs | ~in_frame),
    .load     (1'b0),
    .load_val ('0),
    .inc      (in_frame & ~hs),
    .expired  (to_exp)
  );

  always_comb begin
    state_nxt = state;
    cause     = CAUSE_NONE;
    case (state)
      IDLE: begin
        if (hs && (RX_DATA == SYNC_BYTE)) state_nxt = S_CMD;
      end
      S_CMD: begin
        if (hs) begin
          if (RX_DATA == CMD_WR) begin
            state_nxt = S_A;
          end else begin
            cause     = CAUSE_BAD_CMD;
            state_nxt = IDLE;
          end
        end
      end
      S_A: begin
        if (hs) state_nxt = S_B;
      end
      S_B: begin
        if (hs) begin
`ifdef CFG_FRAME_CHK_EN
          state_nxt = S_CHK;
`else
          state_nxt = COMMIT;
`endif
        end
      end
`ifdef CFG_FRAME_CHK_EN
      S_CHK: begin
        if (hs) begin
          if (RX_DATA == (CMD_WR ^ shadow_a ^ shadow_b)) begin
            state_nxt = COMMIT;
          end else begin
            cause     = CAUSE_BAD_CHK;
            state_nxt = IDLE;
          end
        end
      end
`endif
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Expiry is only raised on a cycle without a handshake, so it never
    // collides with a byte-driven transition above.
    if (to_exp) begin
      cause     = CAUSE_TIMEOUT;
      state_nxt = IDLE;
    end
  end

  // Without the checksum stage the B byte goes straight to the payload
  // register on the same edge that enters COMMIT.
`ifdef CFG_FRAME_CHK_EN
  assign db_load = shadow_b;
`else
  assign db_load = RX_DATA;
`endif

  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      state   <= IDLE;
      DA      <= DA_RST;
      DB      <= DB_RST;
      ERR     <= 1'b0;
      ERR_CNT <= 8'd0;
    end else begin
      state <= state_nxt;
      ERR   <= (cause != CAUSE_NONE);
      if ((cause != CAUSE_NONE) && (ERR_CNT != 8'hFF)) begin
        ERR_CNT <= ERR_CNT + 8'd1;
      end
      // COMMIT always exits to IDLE, so this fires only on entry.
      if (state_nxt == COMMIT) begin
        DA <= shadow_a;
        DB <= db_load;
      end
    end
  end

  // Payload shadows are pure data and need no reset.
  always_ff @(posedge CLKEXT) begin
    if (hs && (state == S_A)) shadow_a <= RX_DATA;
`ifdef CFG_FRAME_CHK_EN
    if (hs && (state == S_B)) shadow_b <= RX_DATA;
`endif
  end

endmodule

// File: doc/cfg_frame_rx.md
Name: cfg_frame_rx

Overview:
- Byte-serial configuration frame receiver directly upstream of the SSFR control register.
- Hunts a sync byte, parses a write frame and checks its XOR checksum.
- On a valid frame, presents the two payload bytes on DA/DB and pulses EN_CONFIG for one cycle so the SSFR loads {DA, DB}.
- Rejects malformed or stalled frames and counts the errors.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- CMD_WR, 8'h01, only accepted command code (SSFR write).
- TIMEOUT, 1000, max idle cycles between bytes inside a frame; 0 disables the timeout.
- TO_W, 16, timeout counter width; TIMEOUT must fit in TO_W bits.

Ports:
- CLKEXT  in  1  system clock, all logic on its rising edge.
- RST  in  1  synchronous active-high reset.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  block accepts the byte; a handshake is RX_VALID & RX_READY.
- DA  out  8  payload high byte, registered.
- DB  out  8  payload low byte, registered.
- EN_CONFIG  out  1  one-cycle load strobe for the SSFR.
- BUSY  out  1  high in any state except IDLE.
- ERR  out  1  one-cycle error pulse.
- ERR_CNT  out  8  saturating error counter.

Behaviour:
- Clock and reset: single clock CLKEXT; reset RST is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - DA = 8'h22, DB = 8'h80 (the SSFR reset halves).
  - EN_CONFIG = 0, ERR = 0, ERR_CNT = 0, BUSY = 0.
  - RX_READY = 1 from the first cycle after reset.
- Reset mid-frame discards the partial frame; DA/DB return to their reset values.
- Frame format: SYNC, CMD, A, B, CHK, where CHK = CMD ^ A ^ B.
- States and transitions, taken only on a handshake unless noted:
  - IDLE: byte == SYNC_BYTE -> S_CMD; any other byte is silently dropped.
  - S_CMD: byte == CMD_WR -> S_A; else ERR -> IDLE.
  - S_A: capture byte into shadow_a -> S_B.
  - S_B: capture byte into shadow_b -> S_CHK.
  - S_CHK: byte == CMD_WR ^ shadow_a ^ shadow_b -> COMMIT; else ERR -> IDLE.
  - COMMIT (one cycle, no handshake):
    - DA <= shadow_a, DB <= shadow_b on entry, so they are valid in the same cycle EN_CONFIG = 1.
    - Next state IDLE.
- RX_READY = 0 only in COMMIT; all bytes are accepted in every other state.
- Latency: EN_CONFIG rises exactly one cycle after the CHK handshake.
- DA/DB change only on entry to COMMIT and hold between commits; failed frames never alter them.
- Timeout:
  - Counter clears on every handshake and in IDLE/COMMIT.
  - It increments each cycle in S_CMD..S_CHK with no handshake.
  - On reaching TIMEOUT: ERR, then IDLE.
  - A handshake in the same cycle as expiry wins; the byte is processed and no error is raised.
- ERR handling:
  - ERR is a single-cycle pulse in the cycle after the error is detected.
  - ERR_CNT increments on each ERR and saturates at 255.
- A SYNC_BYTE value received in S_CMD..S_CHK is treated as ordinary data; there is no resync mid-frame.
- Back-to-back frames: a new SYNC byte is accepted in the cycle after COMMIT.

Optional Feature:
- Macro: CFG_FRAME_CHK_EN.
- Defined: 5-byte frame with the S_CHK state and checksum check as above.
- Undefined:
  - S_CHK is removed; the frame is 4 bytes (SYNC, CMD, A, B).
  - S_B handshake goes directly to COMMIT, so EN_CONFIG follows the B handshake by one cycle.
  - Checksum errors cannot occur.

Decomposition:
- Package npu_cfg_pkg holds:
  - state enum (IDLE, S_CMD, S_A, S_B, S_CHK, COMMIT);
  - SSFR_RST_VAL = 16'h2280, with the DA/DB reset values derived from it;
  - default SYNC/CMD constants;
  - error cause codes (BAD_CMD, BAD_CHK, TIMEOUT) for debug.
- One natural sub-module: cfg_timeout_ctr, a loadable/clearable TO_W-bit counter with an expiry flag.
- Everything else lives in cfg_frame_rx.

Test Plan:
1. Reset check: after reset, DA=22, DB=80, EN_CONFIG=0, ERR_CNT=0, RX_READY=1.
2. Valid frame A5 01 3C 5A 67, fed one byte per cycle:
   - EN_CONFIG=1 for exactly one cycle, one cycle after the last handshake.
   - DA=3C, DB=5A, holding afterwards.
3. Bad checksum A5 01 3C 5A 00:
   - ERR pulses once, ERR_CNT=1.
   - No EN_CONFIG; DA/DB unchanged.
4. Bad command A5 07 ...:
   - ERR pulses after the CMD byte, block returns to IDLE.
   - A following valid frame A5 01 11 22 32 commits DA=11, DB=22.
5. Timeout (TIMEOUT=8):
   - A5 01 then RX_VALID low for 8 cycles -> ERR, BUSY falls.
   - A stall of 7 cycles, then bytes resume -> frame completes normally.
6. Noise and saturation:
   - Bytes 00 FF A4 before A5 are dropped silently, with no ERR.
   - 260 bad frames -> ERR_CNT saturates at FF.
   - Mid-frame RST -> IDLE with DA=22, DB=80.
